// File: rtl/result_streamer_pkg.sv
// rtl/result_streamer_pkg.sv - shared state encoding and constants for result_streamer
package result_streamer_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_LOAD   = 4'd2;
    localparam logic [3:0] ST_ARM    = 4'd3;
    localparam logic [3:0] ST_WAIT   = 4'd4;
    localparam logic [3:0] ST_CSUM   = 4'd5;
    localparam logic [3:0] ST_ARM_C  = 4'd6;
    localparam logic [3:0] ST_WAIT_C = 4'd7;
    localparam logic [3:0] ST_FINISH = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_LOAD   = ST_LOAD,
        S_ARM    = ST_ARM,
        S_WAIT   = ST_WAIT,
        S_CSUM   = ST_CSUM,
        S_ARM_C  = ST_ARM_C,
        S_WAIT_C = ST_WAIT_C,
        S_FINISH = ST_FINISH
    } state_t;

    localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

// File: rtl/result_streamer_tx_gate.sv
// rtl/result_streamer_tx_gate.sv - qualifies a pending byte against host_rts/tx_active and issues tx_dv
//
// Ports:
//   state     in   current streamer state (arm states are ARM and ARM_C)
//   host_rts  in   host ready-to-receive
//   tx_active in   uart_tx busy
//   fire      out  one-cycle tx_dv; the streamer leaves the arm state on the same edge,
//                  so the pulse cannot repeat for the same byte
module result_streamer_tx_gate
    import result_streamer_pkg::*;
(
    input  state_t state,
    input  logic   host_rts,
    input  logic   tx_active,
    output logic   fire
);

    logic armed;

    always_comb begin
        armed = (state == S_ARM) || (state == S_ARM_C);
        // rts is only consulted before a byte is launched; dropping it afterwards
        // leaves the in-flight byte alone.
        fire  = armed && host_rts && !tx_active;
    end

endmodule

// File: rtl/result_streamer.sv
// rtl/result_streamer.sv - streams filtered pixels from output memory to uart_tx with XOR checksum
//
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   start, len   begin a run of len pixels (len clamped to memory depth), ignored while busy
//   host_rts     host flow control, checked before each byte
//   mem_addr     output memory read address; mem_data returns one cycle later
//   tx_byte      byte to uart_tx, stable from tx_dv until tx_done
//   tx_dv        one-cycle launch strobe to uart_tx
//   tx_active    uart_tx busy; tx_done one-cycle completion pulse
//   busy, done   run in progress; one-cycle end-of-run pulse
//   sent_count   pixels completed in the current/last run (checksum byte excluded)
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int ADDR_BITS     = 9,
    parameter int DATA_BITS     = 8,
    parameter int LEN_BITS      = 16,
    parameter int SEND_CHECKSUM = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_BITS-1:0]  len,
    input  logic                 host_rts,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BITS-1:0] mem_data,
    output logic [DATA_BITS-1:0] tx_byte,
    output logic                 tx_dv,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_BITS-1:0]  sent_count
);

    localparam int MAX_LEN = 2 ** ADDR_BITS;

    state_t                state;
    state_t                state_nxt;
    logic [LEN_BITS-1:0]   len_q;
    logic [LEN_BITS-1:0]   len_clamp;
    logic [LEN_BITS-1:0]   sent_next;
    logic [DATA_BITS-1:0]  checksum;
    logic                  last_px;
    logic                  fire;

    // Clamping to the memory depth means mem_addr never has to wrap.
    always_comb begin
        len_clamp = len;
        if (int'(len) > MAX_LEN) begin
            len_clamp = LEN_BITS'(MAX_LEN);
        end
    end

    assign sent_next = sent_count + LEN_BITS'(1);
    assign last_px   = (sent_next == len_q);

    result_streamer_tx_gate u_tx_gate (
        .state     (state),
        .host_rts  (host_rts),
        .tx_active (tx_active),
        .fire      (fire)
    );

    assign tx_dv = fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // A tx_done arriving here belongs to an aborted byte and is ignored.
                if (start) begin
                    if (len_clamp == '0) begin
                        state_nxt = (SEND_CHECKSUM != 0) ? S_CSUM : S_FINISH;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ARM;
            S_ARM: begin
                if (fire) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (last_px) begin
                        state_nxt = (SEND_CHECKSUM != 0) ? S_CSUM : S_FINISH;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_CSUM: state_nxt = S_ARM_C;
            S_ARM_C: begin
                if (fire) begin
                    state_nxt = S_WAIT_C;
                end
            end
            S_WAIT_C: begin
                if (tx_done) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            mem_addr   <= '0;
            tx_byte    <= '0;
            sent_count <= '0;
            checksum   <= DATA_BITS'(CSUM_INIT);
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q      <= len_clamp;
                        mem_addr   <= '0;
                        sent_count <= '0;
                        checksum   <= DATA_BITS'(CSUM_INIT);
                        busy       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    tx_byte  <= mem_data;
                    checksum <= checksum ^ mem_data;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        sent_count <= sent_next;
                        // Holding the address on the last pixel keeps it inside the memory.
                        if (!last_px) begin
                            mem_addr <= mem_addr + ADDR_BITS'(1);
                        end
                    end
                end
                S_CSUM: begin
                    tx_byte <= checksum;
                end
                S_FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
